// File: rtl/bmem_arbiter.sv
// Shares one burst memory port between I-cache line reads and D-cache reads/write-backs.
// Tracks one outstanding read per requester and reassembles returned beats by line address.
module bmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_resp,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((LINE_W / 8) - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_BURST} state_t;

  // Requester index 0 is the I-cache, index 1 is the D-cache.
  logic [1:0]        req_any;
  logic [1:0]        req_rd;
  logic [1:0]        elig;
  logic [1:0]        out_flag;
  logic [1:0]        accept;
  logic [1:0]        rd_done;
  logic [1:0]        resp_pending;
  logic [ADDR_W-1:0] req_line [2];
  logic [ADDR_W-1:0] lat_line [2];
  logic [LINE_W-1:0] rdata_line [2];

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              favor_dc_reg, favor_dc_next;
  logic [CNT_W-1:0]  beat_reg, beat_next;
  logic              bmem_read_reg, bmem_read_next;
  logic              bmem_write_reg, bmem_write_next;
  logic [ADDR_W-1:0] bmem_addr_reg, bmem_addr_next;
  logic [BEAT_W-1:0] bmem_wdata_reg, bmem_wdata_next;
  logic              wr_done_reg, wr_done_next;
  logic              pick_dc;

  assign req_any      = {dc_read | dc_write, ic_read};
  assign req_rd       = {dc_read, ic_read};
  assign req_line[0]  = ic_addr & ~OFF_MASK;
  assign req_line[1]  = dc_addr & ~OFF_MASK;
  assign resp_pending = {dc_resp, ic_resp};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic              out_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic [ADDR_W-1:0] lat_reg;
      logic [LINE_W-1:0] buf_reg, buf_next;
      logic [LINE_W-1:0] rdata_reg;
      logic              done_reg;
      logic              hit;

      // A same-line read waits for the other requester's read to drain.
      assign elig[gi] = req_any[gi] && !out_flag[gi] && !resp_pending[gi] &&
                        !(req_rd[gi] && out_flag[1-gi] && (lat_line[1-gi] == req_line[gi]));

      assign hit = bmem_rvalid && out_reg && (lat_reg == bmem_raddr);

      always_comb begin
        buf_next = buf_reg;
        buf_next[cnt_reg*BEAT_W +: BEAT_W] = bmem_rdata;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_reg   <= 1'b0;
          cnt_reg   <= '0;
          lat_reg   <= '0;
          buf_reg   <= '0;
          rdata_reg <= '0;
          done_reg  <= 1'b0;
        end else begin
          done_reg <= 1'b0;
          if (accept[gi]) begin
            out_reg <= 1'b1;
            lat_reg <= bmem_addr_reg;
            cnt_reg <= '0;
          end else if (hit) begin
            buf_reg <= buf_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_BEAT) begin
              out_reg   <= 1'b0;
              rdata_reg <= buf_next;
              done_reg  <= 1'b1;
            end
          end
        end
      end

      assign out_flag[gi]   = out_reg;
      assign lat_line[gi]   = lat_reg;
      assign rdata_line[gi] = rdata_reg;
      assign rd_done[gi]    = done_reg;
    end
  endgenerate

  // Round-robin: D-cache wins a tie unless it was the last one granted.
  assign pick_dc = elig[1] && (!elig[0] || favor_dc_reg);

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    favor_dc_next   = favor_dc_reg;
    beat_next       = beat_reg;
    bmem_read_next  = bmem_read_reg;
    bmem_write_next = bmem_write_reg;
    bmem_addr_next  = bmem_addr_reg;
    bmem_wdata_next = bmem_wdata_reg;
    wr_done_next    = 1'b0;
    accept          = '0;
    case (state_reg)
      IDLE: begin
        if (|elig) begin
          owner_next     = pick_dc;
          favor_dc_next  = !pick_dc;
          bmem_addr_next = pick_dc ? req_line[1] : req_line[0];
          if (pick_dc && dc_write) begin
            state_next      = WR_BURST;
            bmem_write_next = 1'b1;
            beat_next       = '0;
            bmem_wdata_next = dc_wdata[BEAT_W-1:0];
          end else begin
            state_next     = RD_ISSUE;
            bmem_read_next = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        if (bmem_ready) begin
          bmem_read_next     = 1'b0;
          state_next         = IDLE;
          accept[owner_reg]  = 1'b1;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          if (beat_reg == LAST_BEAT) begin
            bmem_write_next = 1'b0;
            state_next      = IDLE;
            wr_done_next    = 1'b1;
          end else begin
            beat_next       = beat_reg + 1'b1;
            bmem_wdata_next = dc_wdata[(beat_reg + 1'b1)*BEAT_W +: BEAT_W];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      favor_dc_reg   <= 1'b1;
      beat_reg       <= '0;
      bmem_read_reg  <= 1'b0;
      bmem_write_reg <= 1'b0;
      bmem_addr_reg  <= '0;
      bmem_wdata_reg <= '0;
      wr_done_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      favor_dc_reg   <= favor_dc_next;
      beat_reg       <= beat_next;
      bmem_read_reg  <= bmem_read_next;
      bmem_write_reg <= bmem_write_next;
      bmem_addr_reg  <= bmem_addr_next;
      bmem_wdata_reg <= bmem_wdata_next;
      wr_done_reg    <= wr_done_next;
    end
  end

  assign bmem_read  = bmem_read_reg;
  assign bmem_write = bmem_write_reg;
  assign bmem_addr  = bmem_addr_reg;
  assign bmem_wdata = bmem_wdata_reg;
  assign ic_resp    = rd_done[0];
  assign dc_resp    = rd_done[1] | wr_done_reg;
  assign ic_rdata   = rdata_line[0];
  assign dc_rdata   = rdata_line[1];

endmodule

// File: tb/tb_bmem_arbiter.sv
// Randomized self-checking bench for bmem_arbiter; expected lines and pulses come from
// a beat-arrival model of each requester.
module tb_bmem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_read, dc_read, dc_write, ic_resp, dc_resp;
  logic [31:0]  ic_addr, dc_addr, bmem_addr, bmem_raddr;
  logic [255:0] ic_rdata, dc_rdata, dc_wdata;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_read = 0; dc_read = 0; dc_write = 0; ic_addr = 0; dc_addr = 0; dc_wdata = '0;
    bmem_ready = 0; bmem_raddr = 0; bmem_rdata = 0; bmem_rvalid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick();
    rst_n = 1;
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'h1f;
  endfunction

  function automatic logic [63:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_beat(input logic [31:0] a, input logic [63:0] d);
    bmem_rvalid = 1; bmem_raddr = a; bmem_rdata = d;
    tick();
    bmem_rvalid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    ic_read = 1; dc_write = 1; dc_addr = $urandom; dc_wdata = rand_line();
    bmem_ready = 1; bmem_rvalid = 1; bmem_raddr = $urandom; bmem_rdata = rand_beat();
    tick(); tick();
    checks++; if (bmem_read !== 1'b0) begin failures++; $display("FAIL reset_bmem_read got=%0h exp=0", bmem_read); end
    checks++; if (bmem_write !== 1'b0) begin failures++; $display("FAIL reset_bmem_write got=%0h exp=0", bmem_write); end
    checks++; if (bmem_addr !== 32'h0) begin failures++; $display("FAIL reset_bmem_addr got=%0h exp=0", bmem_addr); end
    checks++; if (bmem_wdata !== 64'h0) begin failures++; $display("FAIL reset_bmem_wdata got=%0h exp=0", bmem_wdata); end
    checks++; if (ic_resp !== 1'b0) begin failures++; $display("FAIL reset_ic_resp got=%0h exp=0", ic_resp); end
    checks++; if (dc_resp !== 1'b0) begin failures++; $display("FAIL reset_dc_resp got=%0h exp=0", dc_resp); end
    checks++; if (ic_rdata !== 256'h0) begin failures++; $display("FAIL reset_ic_rdata got=%0h exp=0", ic_rdata); end
    checks++; if (dc_rdata !== 256'h0) begin failures++; $display("FAIL reset_dc_rdata got=%0h exp=0", dc_rdata); end
    idle_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_ic_read();
    logic [31:0] a;
    logic [63:0] b [4];
    logic [255:0] exp;
    int stall;
    do_reset();
    for (int it = 0; it < 3; it++) begin
      a = (it == 0) ? 32'h1000_0044 : $urandom;
      for (int k = 0; k < 4; k++) b[k] = (it == 0) ? {16{4'(k + 1)}} : rand_beat();
      exp = {b[3], b[2], b[1], b[0]};
      bmem_ready = 0; ic_addr = a; ic_read = 1;
      tick();
      checks++; if (bmem_read !== 1'b1 || bmem_addr !== line_of(a)) begin failures++;
        $display("FAIL ic_issue read=%0h addr=%0h exp_addr=%0h", bmem_read, bmem_addr, line_of(a)); end
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        tick();
        checks++; if (bmem_read !== 1'b1 || bmem_addr !== line_of(a)) begin failures++;
          $display("FAIL ic_issue_hold read=%0h addr=%0h exp_addr=%0h", bmem_read, bmem_addr, line_of(a)); end
      end
      bmem_ready = 1;
      tick();
      checks++; if (bmem_read !== 1'b0) begin failures++; $display("FAIL ic_issue_drop read=%0h exp=0", bmem_read); end
      for (int k = 0; k < 4; k++) begin
        drive_beat(line_of(a), b[k]);
        if (k < 3) begin
          checks++; if (ic_resp !== 1'b0) begin failures++; $display("FAIL ic_resp_early beat=%0d got=%0h exp=0", k, ic_resp); end
        end
      end
      checks++; if (ic_resp !== 1'b1 || ic_rdata !== exp) begin failures++;
        $display("FAIL ic_line resp=%0h rdata=%0h exp=%0h", ic_resp, ic_rdata, exp); end
      ic_read = 0;
      tick();
      checks++; if (ic_resp !== 1'b0 || ic_rdata !== exp || dc_resp !== 1'b0) begin failures++;
        $display("FAIL ic_hold resp=%0h rdata=%0h exp=%0h", ic_resp, ic_rdata, exp); end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] a, b;
    logic [255:0] la, lb;
    do_reset();
    a = $urandom; b = $urandom;
    if (line_of(a) == line_of(b)) b = b ^ 32'h8000;
    la = rand_line(); lb = rand_line();
    bmem_ready = 1; ic_addr = a; dc_addr = b; ic_read = 1; dc_read = 1;
    tick();
    checks++; if (bmem_read !== 1'b1 || bmem_addr !== line_of(b)) begin failures++;
      $display("FAIL sim_first read=%0h addr=%0h exp_addr=%0h", bmem_read, bmem_addr, line_of(b)); end
    tick();
    checks++; if (bmem_read !== 1'b0) begin failures++; $display("FAIL sim_gap read=%0h exp=0", bmem_read); end
    tick();
    checks++; if (bmem_read !== 1'b1 || bmem_addr !== line_of(a)) begin failures++;
      $display("FAIL sim_second read=%0h addr=%0h exp_addr=%0h", bmem_read, bmem_addr, line_of(a)); end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_beat(line_of(a), la[k*64 +: 64]);
      checks++; if (dc_resp !== 1'b0) begin failures++; $display("FAIL sim_dc_early beat=%0d got=%0h exp=0", k, dc_resp); end
    end
    checks++; if (ic_resp !== 1'b1 || ic_rdata !== la) begin failures++;
      $display("FAIL sim_ic_line resp=%0h rdata=%0h exp=%0h", ic_resp, ic_rdata, la); end
    ic_read = 0;
    for (int k = 0; k < 4; k++) drive_beat(line_of(b), lb[k*64 +: 64]);
    checks++; if (dc_resp !== 1'b1 || dc_rdata !== lb || ic_resp !== 1'b0) begin failures++;
      $display("FAIL sim_dc_line resp=%0h rdata=%0h exp=%0h", dc_resp, dc_rdata, lb); end
    dc_read = 0;
    tick();
  endtask

  task automatic test_write_stalls();
    logic [31:0] w;
    logic [255:0] wd;
    int acc, c;
    do_reset();
    for (int run = 0; run < 4; run++) begin
      w = $urandom; wd = rand_line();
      dc_addr = w; dc_wdata = wd; dc_write = 1; bmem_ready = 1;
      tick();
      acc = 0; c = 1;
      while (acc < 4 && c < 60) begin
        bmem_ready = (run == 0) ? !(c >= 2 && c <= 4) : ($urandom_range(0, 2) != 0);
        checks++; if (bmem_write !== 1'b1 || bmem_wdata !== wd[acc*64 +: 64] || bmem_addr !== line_of(w)) begin failures++;
          $display("FAIL wr_beat run=%0d beat=%0d write=%0h wdata=%0h exp=%0h addr=%0h", run, acc, bmem_write, bmem_wdata, wd[acc*64 +: 64], bmem_addr); end
        if (bmem_ready) acc++;
        tick();
        c++;
      end
      checks++; if (acc != 4) begin failures++; $display("FAIL wr_timeout run=%0d accepted=%0d exp=4", run, acc); end
      checks++; if (dc_resp !== 1'b1 || bmem_write !== 1'b0) begin failures++;
        $display("FAIL wr_resp run=%0d resp=%0h write=%0h exp=1,0", run, dc_resp, bmem_write); end
      dc_write = 0;
      tick();
      checks++; if (dc_resp !== 1'b0) begin failures++; $display("FAIL wr_resp_pulse run=%0d got=%0h exp=0", run, dc_resp); end
    end
  endtask

  task automatic test_conflict();
    logic [255:0] ld, li;
    do_reset();
    ld = rand_line(); li = rand_line();
    bmem_ready = 1; dc_addr = 32'h2000; dc_read = 1;
    tick();
    checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h2000) begin failures++;
      $display("FAIL cf_dc_issue read=%0h addr=%0h exp_addr=2000", bmem_read, bmem_addr); end
    tick();
    ic_addr = 32'h2010; ic_read = 1;
    repeat (6) begin
      tick();
      checks++; if (bmem_read !== 1'b0) begin failures++; $display("FAIL cf_blocked read=%0h exp=0", bmem_read); end
    end
    for (int k = 0; k < 4; k++) begin
      drive_beat(32'h2000, ld[k*64 +: 64]);
      checks++; if (bmem_read !== 1'b0) begin failures++; $display("FAIL cf_blocked_beats beat=%0d read=%0h exp=0", k, bmem_read); end
    end
    checks++; if (dc_resp !== 1'b1 || dc_rdata !== ld) begin failures++;
      $display("FAIL cf_dc_line resp=%0h rdata=%0h exp=%0h", dc_resp, dc_rdata, ld); end
    dc_read = 0;
    tick();
    checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h2000) begin failures++;
      $display("FAIL cf_ic_issue read=%0h addr=%0h exp_addr=2000", bmem_read, bmem_addr); end
    tick();
    for (int k = 0; k < 4; k++) drive_beat(32'h2000, li[k*64 +: 64]);
    checks++; if (ic_resp !== 1'b1 || ic_rdata !== li) begin failures++;
      $display("FAIL cf_ic_line resp=%0h rdata=%0h exp=%0h", ic_resp, ic_rdata, li); end
    ic_read = 0;
    tick();
  endtask

  task automatic test_interleaved();
    logic [31:0] ln [2];
    logic [31:0] stray;
    logic [255:0] exp [2];
    logic [63:0] d;
    int cnt [2];
    int r, sel, cycles;
    logic [1:0] fin;
    do_reset();
    ln[0] = line_of($urandom); ln[1] = line_of($urandom);
    if (ln[0] == ln[1]) ln[1] = ln[1] ^ 32'h4000;
    exp[0] = '0; exp[1] = '0; cnt[0] = 0; cnt[1] = 0; cycles = 0;
    bmem_ready = 1; ic_addr = ln[0] | 32'h8; dc_addr = ln[1] | 32'h18; ic_read = 1; dc_read = 1;
    tick(); tick(); tick(); tick();
    checks++; if (bmem_read !== 1'b0) begin failures++; $display("FAIL il_issue read=%0h exp=0", bmem_read); end
    while ((cnt[0] < 4 || cnt[1] < 4) && cycles < 100) begin
      r = $urandom_range(0, 4);
      fin = 2'b00;
      if (r == 1) begin
        stray = line_of($urandom);
        while (stray == ln[0] || stray == ln[1]) stray = stray ^ 32'h20;
        bmem_rvalid = 1; bmem_raddr = stray; bmem_rdata = rand_beat();
      end else if (r >= 2) begin
        sel = (cnt[0] == 4) ? 1 : (cnt[1] == 4) ? 0 : $urandom_range(0, 1);
        d = rand_beat();
        exp[sel][cnt[sel]*64 +: 64] = d;
        cnt[sel]++;
        fin[sel] = (cnt[sel] == 4);
        bmem_rvalid = 1; bmem_raddr = ln[sel]; bmem_rdata = d;
      end
      tick();
      bmem_rvalid = 0;
      cycles++;
      checks++; if (ic_resp !== fin[0] || dc_resp !== fin[1]) begin failures++;
        $display("FAIL il_resp cycle=%0d ic=%0h dc=%0h exp=%0h,%0h", cycles, ic_resp, dc_resp, fin[0], fin[1]); end
      if (fin[0]) begin
        checks++; if (ic_rdata !== exp[0]) begin failures++; $display("FAIL il_ic_line got=%0h exp=%0h", ic_rdata, exp[0]); end
        ic_read = 0;
      end
      if (fin[1]) begin
        checks++; if (dc_rdata !== exp[1]) begin failures++; $display("FAIL il_dc_line got=%0h exp=%0h", dc_rdata, exp[1]); end
        dc_read = 0;
      end
    end
    checks++; if (cnt[0] != 4 || cnt[1] != 4) begin failures++; $display("FAIL il_timeout ic=%0d dc=%0d exp=4,4", cnt[0], cnt[1]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [255:0] wd;
    tick();
    a = $urandom; wd = rand_line();
    bmem_ready = 1; ic_addr = a; ic_read = 1;
    tick(); tick();
    dc_addr = line_of(a) ^ 32'h100; dc_wdata = wd; dc_write = 1;
    tick(); tick(); tick();
    checks++; if (bmem_write !== 1'b1 || bmem_wdata !== wd[128 +: 64]) begin failures++;
      $display("FAIL rm_beat2 write=%0h wdata=%0h exp=%0h", bmem_write, bmem_wdata, wd[128 +: 64]); end
    rst_n = 0; ic_read = 0; dc_write = 0;
    tick();
    rst_n = 1;
    checks++; if ({bmem_read, bmem_write, ic_resp, dc_resp} !== 4'b0 || bmem_addr !== 32'h0 || bmem_wdata !== 64'h0) begin failures++;
      $display("FAIL rm_outputs read=%0h write=%0h addr=%0h wdata=%0h resp=%0h%0h exp=0", bmem_read, bmem_write, bmem_addr, bmem_wdata, ic_resp, dc_resp); end
    checks++; if (ic_rdata !== 256'h0 || dc_rdata !== 256'h0) begin failures++;
      $display("FAIL rm_rdata ic=%0h dc=%0h exp=0", ic_rdata, dc_rdata); end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_beat(line_of(a), rand_beat()); else tick();
      checks++; if (ic_resp !== 1'b0 || dc_resp !== 1'b0 || bmem_read !== 1'b0) begin failures++;
        $display("FAIL rm_stray k=%0d ic_resp=%0h dc_resp=%0h read=%0h exp=0", k, ic_resp, dc_resp, bmem_read); end
    end
  endtask

  task automatic test_coincident();
    logic [31:0] a;
    logic [255:0] la, wd;
    do_reset();
    a = $urandom; la = rand_line(); wd = rand_line();
    bmem_ready = 1; ic_addr = a; ic_read = 1;
    tick(); tick();
    for (int k = 0; k < 3; k++) drive_beat(line_of(a), la[k*64 +: 64]);
    dc_addr = line_of(a) ^ 32'h40; dc_wdata = wd; dc_write = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bmem_write !== 1'b1 || bmem_wdata !== wd[k*64 +: 64]) begin failures++;
        $display("FAIL co_beat k=%0d write=%0h wdata=%0h exp=%0h", k, bmem_write, bmem_wdata, wd[k*64 +: 64]); end
    end
    bmem_rvalid = 1; bmem_raddr = line_of(a); bmem_rdata = la[192 +: 64];
    tick();
    bmem_rvalid = 0;
    checks++; if (ic_resp !== 1'b1 || dc_resp !== 1'b1 || ic_rdata !== la) begin failures++;
      $display("FAIL co_both ic_resp=%0h dc_resp=%0h ic_rdata=%0h exp=%0h", ic_resp, dc_resp, ic_rdata, la); end
    ic_read = 0; dc_write = 0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_ic_read();
    test_simultaneous();
    test_write_stalls();
    test_conflict();
    test_interleaved();
    test_reset_mid();
    test_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
